// File: rtl/request_pkg.sv
// request_pkg
// Shared definitions for the request scheduler:
//   - state_t   : scheduler FSM states (IDLE, UP, DOWN, DOOR) and their encoding
//   - DEFAULT_N_FLOORS : default building height
//   - floor_vec_t      : widest floor vector the helpers accept (MAX_FLOORS bits)
//   - above_mask / below_mask : floors strictly above / below a one-hot floor
//   - is_onehot        : exactly one bit set
// Helpers work on MAX_FLOORS-wide vectors; callers zero-extend their
// N_FLOORS-wide vectors on the way in and truncate the result on the way out.
package request_pkg;

    localparam int DEFAULT_N_FLOORS = 6;
    localparam int MAX_FLOORS       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DOOR = 2'd3
    } state_t;

    typedef logic [MAX_FLOORS-1:0] floor_vec_t;

    // Bit i is set when the one-hot floor f sits below floor i.
    function automatic floor_vec_t above_mask(input floor_vec_t f);
        floor_vec_t m;
        logic       seen;
        m    = '0;
        seen = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            m[i] = seen;
            seen = seen | f[i];
        end
        return m;
    endfunction

    // Bit i is set when the one-hot floor f sits above floor i.
    function automatic floor_vec_t below_mask(input floor_vec_t f);
        floor_vec_t m;
        logic       seen;
        m    = '0;
        seen = 1'b0;
        for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
            m[i] = seen;
            seen = seen | f[i];
        end
        return m;
    endfunction

    function automatic logic is_onehot(input floor_vec_t f);
        return (f != '0) && ((f & (f - floor_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/request_latch.sv
// request_latch
// Persistent request register for one request class (cab, hall-up or
// hall-down). A bit is set by its button and held until cleared.
//   clk, rst  : clock, asynchronous active-high reset
//   set_bits  : button inputs (level or pulse)
//   clr_bits  : floors served this cycle
//   pend      : latched requests
// KEEP masks floors whose button does not exist for this class (top-floor
// up, ground-floor down); those bits never latch. Clear beats a same-edge set.
module request_latch
    import request_pkg::*;
#(
    parameter int           N    = DEFAULT_N_FLOORS,
    parameter logic [N-1:0] KEEP = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] set_bits,
    input  logic [N-1:0] clr_bits,
    output logic [N-1:0] pend
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend | set_bits) & ~clr_bits & KEEP;
        end
    end

endmodule

// File: rtl/request_scheduler.sv
// request_scheduler
// Latches cab and hall requests and runs a direction-preserving (collective)
// scheduler that drives the motor and door commands.
//   clk, rst            : clock, asynchronous active-high reset
//   cur_floor           : one-hot car position, meaningful while floor_valid=1
//   floor_valid         : car is level at cur_floor and may stop
//   req_in / up / down  : cab / hall-up / hall-down buttons
//   open_bt, close_bt   : door buttons
//   door_done           : one-cycle pulse, door has closed again
//   pend_in/up/down     : latched request vectors
//   motor_up/motor_down : motor commands (mutually exclusive)
//   door_open           : hold the door open
//   door_close          : close_bt delayed one cycle
//   dir_up              : service direction (1 = up)
//   floor_err           : cur_floor not one-hot while floor_valid=1
//   state_dbg           : current FSM state (state_t encoding)
// Optional feature macro: REQ_PARK_EN enables parking at floor 0 after
// PARK_CYCLES idle cycles with nothing pending.
// All outputs come straight from flops.
module request_scheduler
    import request_pkg::*;
#(
    parameter int N_FLOORS    = DEFAULT_N_FLOORS,
    parameter int PARK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] cur_floor,
    input  logic                floor_valid,
    input  logic [N_FLOORS-1:0] req_in,
    input  logic [N_FLOORS-1:0] up,
    input  logic [N_FLOORS-1:0] down,
    input  logic                open_bt,
    input  logic                close_bt,
    input  logic                door_done,
    output logic [N_FLOORS-1:0] pend_in,
    output logic [N_FLOORS-1:0] pend_up,
    output logic [N_FLOORS-1:0] pend_down,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic                door_close,
    output logic                dir_up,
    output logic                floor_err,
    output logic [1:0]          state_dbg
);

    localparam logic [N_FLOORS-1:0] ALL_FLOORS = '1;
    localparam logic [N_FLOORS-1:0] UP_KEEP    = ALL_FLOORS >> 1;  // no up button at the top
    localparam logic [N_FLOORS-1:0] DOWN_KEEP  = ALL_FLOORS << 1;  // no down button at the ground

    state_t state, state_d;
    logic   dir_d;
    logic   flip_clr;

    logic [N_FLOORS-1:0] pos_q;      // last floor the car was seen level at
    logic [N_FLOORS-1:0] here;
    logic [N_FLOORS-1:0] pend_all;
    logic [N_FLOORS-1:0] above_m, below_m;
    logic [N_FLOORS-1:0] clr_in, clr_up, clr_down;
    logic                cur_ok, err_c;
    logic                any_above, any_below, any_here, any_pend;
    logic                at_top, at_bot;
    logic                stop_up, stop_down;

    // ---------------------------------------------------------------
    // Position and request summaries
    // ---------------------------------------------------------------
    assign cur_ok = is_onehot(floor_vec_t'(cur_floor));
    assign err_c  = floor_valid & ~cur_ok;

    // Between floors the last level position still defines above/below,
    // so an idle car that is not level keeps a sensible reference.
    assign here = (floor_valid && cur_ok) ? cur_floor : pos_q;

    assign above_m = N_FLOORS'(above_mask(floor_vec_t'(here)));
    assign below_m = N_FLOORS'(below_mask(floor_vec_t'(here)));

    assign pend_all  = pend_in | pend_up | pend_down;
    assign any_above = |(pend_all & above_m);
    assign any_below = |(pend_all & below_m);
    assign any_here  = |(pend_all & here);
    assign any_pend  = |pend_all;
    assign at_top    = here[N_FLOORS-1];
    assign at_bot    = here[0];

    // Collective stopping: only stop for hall calls in the travel direction,
    // or when nothing lies further ahead.
    assign stop_up   = (|(here & (pend_in | pend_up)))   || !any_above;
    assign stop_down = (|(here & (pend_in | pend_down))) || !any_below;

`ifdef REQ_PARK_EN
    localparam int PW = $clog2(PARK_CYCLES + 1);

    logic [PW-1:0] park_cnt;
    logic          park_q, park_d, park_hit;

    assign park_hit = (park_cnt == PW'(PARK_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            park_cnt <= '0;
            park_q   <= 1'b0;
        end else begin
            park_q <= park_d;
            if ((state != IDLE) || (state_d != state) || any_pend) begin
                park_cnt <= '0;
            end else if (!park_hit) begin
                park_cnt <= park_cnt + 1'b1;
            end
        end
    end
`else
    // Parking is compiled out; the parameter is kept for a uniform interface.
    logic park_unused;
    assign park_unused = (PARK_CYCLES > 0);
`endif

    // ---------------------------------------------------------------
    // Scheduler FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state;
        dir_d    = dir_up;
        flip_clr = 1'b0;
`ifdef REQ_PARK_EN
        park_d   = park_q;
`endif
        if (err_c) begin
            state_d = IDLE;
`ifdef REQ_PARK_EN
            park_d  = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (floor_valid && (any_here || open_bt)) begin
                        state_d = DOOR;
                    end else if (any_above) begin
                        state_d = UP;
                        dir_d   = 1'b1;
                    end else if (any_below) begin
                        state_d = DOWN;
                        dir_d   = 1'b0;
                    end
`ifdef REQ_PARK_EN
                    else if (park_hit && !at_bot) begin
                        state_d = DOWN;
                        dir_d   = 1'b0;
                        park_d  = 1'b1;
                    end
`endif
                end
                UP: begin
                    if (floor_valid && stop_up) begin
                        state_d = DOOR;
                    end
                end
                DOWN: begin
`ifdef REQ_PARK_EN
                    // Parking run: no real target, so the normal stop rule
                    // would fire immediately; only floor 0 or a new request
                    // ends it, and never with the door opening.
                    if (park_q) begin
                        if (any_pend || (floor_valid && at_bot)) begin
                            state_d = IDLE;
                            park_d  = 1'b0;
                        end
                    end else
`endif
                    if (floor_valid && stop_down) begin
                        state_d = DOOR;
                    end
                end
                DOOR: begin
                    if (door_done) begin
                        if (dir_up ? any_above : any_below) begin
                            state_d = dir_up ? UP : DOWN;
                        end else if (dir_up ? |(here & pend_down) : |(here & pend_up)) begin
                            // Serve the opposite hall call here with a second
                            // door cycle before turning around.
                            dir_d    = ~dir_up;
                            flip_clr = 1'b1;
                        end else if (dir_up ? any_below : any_above) begin
                            dir_d   = ~dir_up;
                            state_d = dir_up ? DOWN : UP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Request clearing while the door is open at the current floor
    // ---------------------------------------------------------------
    always_comb begin
        clr_in   = '0;
        clr_up   = '0;
        clr_down = '0;
        if ((state == DOOR) && !err_c) begin
            clr_in = here;
            if (dir_up || at_bot || (flip_clr && !dir_up)) begin
                clr_up = here;
            end
            if (!dir_up || at_top || (flip_clr && dir_up)) begin
                clr_down = here;
            end
        end
    end

    request_latch #(.N(N_FLOORS), .KEEP(ALL_FLOORS)) u_latch_in (
        .clk      (clk),
        .rst      (rst),
        .set_bits (req_in),
        .clr_bits (clr_in),
        .pend     (pend_in)
    );

    request_latch #(.N(N_FLOORS), .KEEP(UP_KEEP)) u_latch_up (
        .clk      (clk),
        .rst      (rst),
        .set_bits (up),
        .clr_bits (clr_up),
        .pend     (pend_up)
    );

    request_latch #(.N(N_FLOORS), .KEEP(DOWN_KEEP)) u_latch_down (
        .clk      (clk),
        .rst      (rst),
        .set_bits (down),
        .clr_bits (clr_down),
        .pend     (pend_down)
    );

    // ---------------------------------------------------------------
    // State and registered outputs. Outputs decode the next state so
    // they line up with the state register without an extra cycle.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir_up     <= 1'b1;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
            door_close <= 1'b0;
            floor_err  <= 1'b0;
            pos_q      <= N_FLOORS'(1);
        end else begin
            state      <= state_d;
            dir_up     <= dir_d;
            motor_up   <= (state_d == UP);
            motor_down <= (state_d == DOWN);
            door_open  <= (state_d == DOOR);
            door_close <= close_bt;
            floor_err  <= err_c;
            if (floor_valid && cur_ok) begin
                pos_q <= cur_floor;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_request_scheduler.sv
// tb_request_scheduler
// Self-checking bench for request_scheduler (N_FLOORS=6, PARK_CYCLES=8):
// reset values, a vector table for latching, hand-written travel/door
// sequences with a simple car plant, and randomized phases checked against
// a set-based request model.
module tb_request_scheduler;
    import request_pkg::*;

    localparam int N = 6;
    localparam int W = 3 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] cur_floor, req_in, up, down;
    logic         floor_valid, open_bt, close_bt, door_done;
    logic [N-1:0] pend_in, pend_up, pend_down;
    logic         motor_up, motor_down, door_open, door_close, dir_up, floor_err;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int car_idx;
    int travel;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] r, u, d;
        logic         c;
        logic [N-1:0] e_in, e_up, e_dn;
        logic         e_close, e_mup;
    } vec_t;

    always #5 clk = ~clk;

    request_scheduler #(.N_FLOORS(N), .PARK_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cur_floor   (cur_floor),
        .floor_valid (floor_valid),
        .req_in      (req_in),
        .up          (up),
        .down        (down),
        .open_bt     (open_bt),
        .close_bt    (close_bt),
        .door_done   (door_done),
        .pend_in     (pend_in),
        .pend_up     (pend_up),
        .pend_down   (pend_down),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .door_open   (door_open),
        .door_close  (door_close),
        .dir_up      (dir_up),
        .floor_err   (floor_err),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int floor);
        rst = 1'b1;
        req_in = '0; up = '0; down = '0;
        open_bt = 1'b0; close_bt = 1'b0; door_done = 1'b0;
        car_idx = floor; travel = 0;
        floor_valid = 1'b1;
        cur_floor = N'(1) << floor;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Car plant: three cycles between floors, level for one cycle on arrival.
    task automatic step_car(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (motor_up || motor_down) begin
                travel++;
                floor_valid = 1'b0;
                if (travel == 3) begin
                    if (motor_up && car_idx < N - 1) car_idx++;
                    else if (motor_down && car_idx > 0) car_idx--;
                    travel = 0;
                    floor_valid = 1'b1;
                end
            end else begin
                travel = 0;
                floor_valid = 1'b1;
            end
            cur_floor = N'(1) << car_idx;
        end
    endtask

    task automatic press(input logic [N-1:0] r, input logic [N-1:0] u, input logic [N-1:0] d);
        req_in = r; up = u; down = d;
        step_car(1);
        req_in = '0; up = '0; down = '0;
    endtask

    task automatic pulse_done();
        door_done = 1'b1;
        tick();
        door_done = 1'b0;
    endtask

    task automatic run_to_door(input string name, input int exp_floor, input int budget);
        int i;
        i = 0;
        while (!door_open && i < budget) begin
            step_car(1);
            i++;
        end
        check({name, "_door_open"}, 32'(door_open), 32'(1));
        check({name, "_stop_floor"}, 32'(car_idx), 32'(exp_floor));
    endtask

    function automatic logic [N-1:0] rand_bits();
        logic [N-1:0] v;
        for (int f = 0; f < N; f++) v[f] = ($urandom_range(0, 15) == 0);
        return v;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t         tbl[5];
        logic [W-1:0] expv;
        logic [N-1:0] ein, eup, edn, rr, uu, dd;
        logic         emu, cl, above_seen, door_seen;
        int           first_md, steps;

        // ---------------- reset values ----------------
        do_reset(0);
        rst = 1'b1;
        tick();
        check("rst_pend", 32'({pend_in, pend_up, pend_down}), 32'(0));
        check("rst_motors", 32'({motor_up, motor_down}), 32'(0));
        check("rst_door", 32'({door_open, door_close}), 32'(0));
        check("rst_floor_err", 32'(floor_err), 32'(0));
        check("rst_dir_up", 32'(dir_up), 32'(1));
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // ---------------- vector table: latching, car not level ----------------
        tbl[0] = '{6'b000000, 6'b000000, 6'b000000, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[1] = '{6'b000001, 6'b100000, 6'b000001, 1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b1, 1'b0};
        tbl[2] = '{6'b000000, 6'b000010, 6'b100000, 1'b0, 6'b000001, 6'b000010, 6'b100000, 1'b0, 1'b0};
        tbl[3] = '{6'b001000, 6'b000000, 6'b000100, 1'b1, 6'b001001, 6'b000010, 6'b100100, 1'b1, 1'b1};
        tbl[4] = '{6'b000000, 6'b000000, 6'b000000, 1'b0, 6'b001001, 6'b000010, 6'b100100, 1'b0, 1'b1};
        do_reset(0);
        floor_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_in = tbl[i].r; up = tbl[i].u; down = tbl[i].d; close_bt = tbl[i].c;
            tick();
            check($sformatf("tbl%0d_pend_in", i), 32'(pend_in), 32'(tbl[i].e_in));
            check($sformatf("tbl%0d_pend_up", i), 32'(pend_up), 32'(tbl[i].e_up));
            check($sformatf("tbl%0d_pend_down", i), 32'(pend_down), 32'(tbl[i].e_dn));
            check($sformatf("tbl%0d_door_close", i), 32'(door_close), 32'(tbl[i].e_close));
            check($sformatf("tbl%0d_motor_up", i), 32'(motor_up), 32'(tbl[i].e_mup));
        end
        req_in = '0; up = '0; down = '0; close_bt = 1'b0;

        // ---------------- A: cab call from ground to floor 4 ----------------
        do_reset(0);
        press(6'b010000, '0, '0);
        check("A_pend_latched", 32'(pend_in), 32'(6'b010000));
        check("A_not_moving_yet", 32'(motor_up), 32'(0));
        run_to_door("A", 4, 100);
        check("A_dir_up", 32'(dir_up), 32'(1));
        check("A_motor_off", 32'({motor_up, motor_down}), 32'(0));
        step_car(2);
        check("A_pend_cleared", 32'(pend_in), 32'(0));
        pulse_done();
        check("A_idle_door_closed", 32'(door_open), 32'(0));

        // ---------------- B: pass a down call, serve top, return ----------------
        do_reset(1);
        press(6'b100000, '0, '0);
        steps = 0;
        while (car_idx != 2 && steps < 40) begin
            step_car(1);
            steps++;
        end
        check("B_reached_floor2", 32'(car_idx), 32'(2));
        press('0, '0, 6'b001000);
        run_to_door("B_top", 5, 100);
        step_car(2);
        check("B_top_pend_in", 32'(pend_in), 32'(0));
        check("B_down_kept", 32'(pend_down), 32'(6'b001000));
        pulse_done();
        check("B_flip_dir", 32'(dir_up), 32'(0));
        check("B_motor_down", 32'(motor_down), 32'(1));
        check("B_door_closed", 32'(door_open), 32'(0));
        run_to_door("B_down", 3, 100);
        step_car(2);
        check("B_down_cleared", 32'(pend_down), 32'(0));
        pulse_done();
        check("B_idle", 32'({motor_up, motor_down, door_open}), 32'(0));

        // ---------------- C: both hall calls at current floor ----------------
        do_reset(2);
        press('0, 6'b000100, 6'b000100);
        tick();
        check("C_door_open", 32'(door_open), 32'(1));
        tick();
        check("C_up_cleared", 32'(pend_up), 32'(0));
        check("C_down_held", 32'(pend_down), 32'(6'b000100));
        pulse_done();
        check("C_dir_flipped", 32'(dir_up), 32'(0));
        check("C_door_still_open", 32'(door_open), 32'(1));
        check("C_down_cleared", 32'(pend_down), 32'(0));
        tick();
        pulse_done();
        check("C_idle", 32'({motor_up, motor_down, door_open}), 32'(0));

        // ---------------- D: floor_err while moving up ----------------
        do_reset(0);
        press(6'b010000, '0, '0);
        tick();
        check("D_moving", 32'(motor_up), 32'(1));
        cur_floor = 6'b000110;
        floor_valid = 1'b1;
        tick();
        check("D_floor_err", 32'(floor_err), 32'(1));
        check("D_motors_off", 32'({motor_up, motor_down}), 32'(0));
        check("D_pend_kept", 32'({pend_in, pend_up, pend_down}), 32'({6'b010000, 6'b000000, 6'b000000}));
        cur_floor = 6'b000001;
        tick();
        check("D_err_clears", 32'(floor_err), 32'(0));

        // ---------------- E: reset while moving down ----------------
        do_reset(3);
        press(6'b000001, '0, '0);
        tick();
        check("E_moving_down", 32'({motor_down, dir_up}), 32'(2'b10));
        rst = 1'b1;
        #1;
        check("E_async_motors", 32'({motor_up, motor_down}), 32'(0));
        check("E_async_dir", 32'(dir_up), 32'(1));
        check("E_async_pend", 32'({pend_in, pend_up, pend_down}), 32'(0));
        check("E_async_door", 32'({door_open, floor_err}), 32'(0));

        // ---------------- parking ----------------
        do_reset(4);
`ifdef REQ_PARK_EN
        first_md = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (motor_down && first_md == 0) first_md = n;
        end
        check("park_start_cycle", 32'(first_md), 32'(8));
        door_seen = 1'b0;
        steps = 0;
        while ((motor_down || car_idx != 0) && steps < 100) begin
            step_car(1);
            if (door_open) door_seen = 1'b1;
            steps++;
        end
        check("park_floor0", 32'(car_idx), 32'(0));
        check("park_stopped", 32'(motor_down), 32'(0));
        check("park_no_door", 32'(door_seen), 32'(0));
`else
        first_md = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (motor_down || motor_up) first_md++;
        end
        check("no_park_stays_idle", 32'(first_md), 32'(0));
`endif

        // ---------------- R1: random presses, car not level ----------------
        do_reset(0);
        floor_valid = 1'b0;
        ein = '0; eup = '0; edn = '0; emu = 1'b0;
        for (int k = 0; k < 150; k++) begin
            rr = rand_bits(); uu = rand_bits(); dd = rand_bits();
            cl = 1'($urandom_range(0, 1));
            above_seen = 1'b0;
            for (int f = 1; f < N; f++) if (ein[f] || eup[f] || edn[f]) above_seen = 1'b1;
            emu = emu | above_seen;
            for (int f = 0; f < N; f++) begin
                if (rr[f]) ein[f] = 1'b1;
                if (uu[f] && f != N - 1) eup[f] = 1'b1;
                if (dd[f] && f != 0) edn[f] = 1'b1;
            end
            exp_q.push_back({ein, eup, edn});
            req_in = rr; up = uu; down = dd; close_bt = cl;
            open_bt = 1'($urandom_range(0, 1));
            cur_floor = N'($urandom);
            tick();
            expv = exp_q.pop_front();
            check("r1_pend", 32'({pend_in, pend_up, pend_down}), 32'(expv));
            check("r1_motor_up", 32'(motor_up), 32'(emu));
            check("r1_motor_down", 32'(motor_down), 32'(0));
            check("r1_door_open", 32'(door_open), 32'(0));
            check("r1_door_close", 32'(door_close), 32'(cl));
        end
        req_in = '0; up = '0; down = '0; open_bt = 1'b0; close_bt = 1'b0;

        // ---------------- R2: random positions, floor_err ----------------
        do_reset(0);
        for (int k = 0; k < 150; k++) begin
            floor_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) cur_floor = N'(1) << $urandom_range(0, N - 1);
            else cur_floor = N'($urandom);
            req_in = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
            door_done = ($urandom_range(0, 7) == 0);
            exp_q.push_back(W'(floor_valid && ($countones(cur_floor) != 1)));
            tick();
            expv = exp_q.pop_front();
            check("r2_floor_err", 32'(floor_err), 32'(expv));
            check("r2_motor_excl", 32'(motor_up & motor_down), 32'(0));
            if (floor_err) check("r2_err_motor_off", 32'(motor_up | motor_down), 32'(0));
        end
        req_in = '0; door_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/request_scheduler.md
# request_scheduler

Parametrised, clocked successor to the combinational request decoder. It latches cab and hall requests for N_FLOORS floors and holds them until served. A direction-preserving (collective) scheduler FSM drives the motor-up/motor-down/door-open commands. It sits between the button panels and the motor/door controllers and replaces per-cycle request comparison with registered, persistent request state.

## Interface
- N_FLOORS, 6, number of floors; all floor vectors are one bit per floor, bit 0 = ground.
- PARK_CYCLES, 1000, idle cycles before parking; used only with REQ_PARK_EN.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cur_floor  in  N_FLOORS  one-hot car position; valid only while floor_valid=1.
- floor_valid  in  1  car is level at cur_floor and may stop.
- req_in  in  N_FLOORS  cab buttons, level or pulse.
- up  in  N_FLOORS  hall up buttons; bit N_FLOORS-1 is ignored.
- down  in  N_FLOORS  hall down buttons; bit 0 is ignored.
- open_bt, close_bt  in  1  door buttons.
- door_done  in  1  one-cycle pulse from the door controller: door is closed again.
- pend_in, pend_up, pend_down  out  N_FLOORS  latched request vectors.
- motor_up, motor_down  out  1  registered motor commands, never both 1.
- door_open  out  1  request to the door controller to open and hold.
- door_close  out  1  close_bt registered, one cycle late.
- dir_up  out  1  current service direction (1 = up, 0 = down).
- floor_err  out  1  cur_floor is not one-hot while floor_valid=1.

## Operation
- **Latching.** Each pend bit is set by the matching button bit and stays set until cleared. Set and clear take effect on the same clock edge.
- **Above/below masks.** "Above" means any pend bit at an index greater than the current floor index. "Below" means any pend bit at a lower index.
- **IDLE**
  - Pending request at the current floor, or open_bt with floor_valid → DOOR.
  - Else requests above → UP, dir_up=1.
  - Else requests below → DOWN, dir_up=0.
- **UP**
  - motor_up=1.
  - When floor_valid=1, stop (→ DOOR) if any of: pend_in at cur, pend_up at cur, no requests above.
- **DOWN**
  - Mirror of UP, using pend_down.
- **DOOR**
  - door_open=1.
  - Every cycle: clear pend_in at cur, and clear the hall bit at cur that matches dir_up.
  - At the top floor, pend_down is cleared; at the bottom floor, pend_up is cleared.
  - Clear wins over a same-cycle press at the current floor.
- **On door_done**
  - Requests ahead in dir → UP/DOWN.
  - Else, if the opposite hall bit at cur is pending: flip dir_up, clear that bit, stay in DOOR, and wait for another door_done.
  - Else, requests behind → flip dir_up and move.
  - Else → IDLE.
- **open_bt in DOOR** has no effect on the FSM; the door controller owns re-opening.
- **floor_err**
  - Forces motors off and the FSM to IDLE on the next edge.
  - Pend vectors are preserved.

## Timing
- Button to pend bit: 1 cycle.
- Stop decision: motor_up/motor_down drop, and door_open rises, on the edge after floor_valid samples a stop condition (1-cycle latency).
- door_done to motor start: 1 cycle.
- All outputs are registered.
- Reset values:
  - State IDLE, all pend vectors 0.
  - motor_up, motor_down, door_open, door_close, floor_err = 0.
  - dir_up = 1.
- Reset asserted mid-travel: motors drop immediately (asynchronously) and requests are lost.

## Configuration
- REQ_PARK_EN defined:
  - A counter increments in IDLE with nothing pending and resets on any request or state change.
  - At PARK_CYCLES the FSM enters DOWN with a synthetic target of floor 0. Any real request aborts parking on the next edge.
  - Parking stops at floor 0 without opening the door.
- REQ_PARK_EN undefined:
  - No counter. The car stays in IDLE indefinitely.

## Structure
- Package request_pkg holds:
  - State enum (IDLE, UP, DOWN, DOOR) and its encoding.
  - Default N_FLOORS.
  - Helper functions: above-mask and below-mask generation from a one-hot floor, and a one-hot check.
- Sub-module request_latch: one instance per request class. Handles set/clear, ignored end bits, and clear-priority.

## Test plan
- N=6, idle at floor 0 (6'b000001), req_in=6'b010000 pulsed 1 cycle → pend_in=6'b010000 next cycle; UP; stops at 6'b010000; door_open=1; pend_in cleared.
- Moving UP from floor 1 to floor 5, down=6'b001000 pressed → car passes floor 3 without stopping, serves floor 5, flips to DOWN, stops at floor 3, pend_down cleared.
- In DOOR at floor 2 with dir_up=1 and up=down=6'b000100 pending → first door_done clears down, dir_up=0, door stays open; second door_done → IDLE.
- cur_floor=6'b000110 with floor_valid=1 while UP → floor_err=1 and motor_up=0 next cycle; pend vectors unchanged.
- rst asserted while motor_down=1 → all outputs 0 immediately; dir_up=1; pend vectors all 0.
- With REQ_PARK_EN and PARK_CYCLES=8, idle at floor 4 with no requests → motor_down after 8 cycles; arrival at floor 0 with door_open=0.
